// File: rtl/sobel_hls_deadlock_pkg.sv
// Shared types and default sizing for the Sobel HLS deadlock reporter.
package sobel_hls_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WATCH  = 2'd1,
    ST_REPORT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int DEF_THRESHOLD = 16;
  localparam int DEF_CNT_W     = 32;
  localparam int RUN_W         = 16;

endpackage

// File: rtl/sobel_hls_deadlock_reporter.sv
// Turns a persistent deadlock flag from the sobel_inst monitor into one
// timestamped, handshaked report carrying the blocked-channel/idle snapshot.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | no deadlock suspected, run count zero
//  ST_WATCH  | block seen high, counting consecutive high cycles
//  ST_REPORT | report_valid high, payload frozen until report_ready
//  ST_HOLD   | report consumed, deadlock sticky until clear
module sobel_hls_deadlock_reporter
  import sobel_hls_deadlock_pkg::*;
#(
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             block,
  input  logic [2:0]       axis_block_sigs,
  input  logic [2:0]       inst_idle_sigs,
  input  logic             clear,
  output logic             report_valid,
  input  logic             report_ready,
  output logic [2:0]       report_chan,
  output logic [2:0]       report_idle,
  output logic [CNT_W-1:0] report_time,
  output logic             deadlock
);

  localparam logic [RUN_W-1:0] THR_M1 = RUN_W'(THRESHOLD - 1);

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] ts_q;
  logic [2:0]       chan_q, idle_q;
  logic [CNT_W-1:0] time_q;
  logic             capture;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    capture = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      run_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (block) begin
            run_d = RUN_W'(1);
            if (THRESHOLD == 1) begin
              state_d = ST_REPORT;
              capture = 1'b1;
            end else begin
              state_d = ST_WATCH;
            end
          end
        end
        ST_WATCH: begin
          if (!block) begin
            state_d = ST_IDLE;
            run_d   = '0;
          end else if (run_q == THR_M1) begin
            state_d = ST_REPORT;
            capture = 1'b1;
            run_d   = run_q + RUN_W'(1);
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end
        ST_REPORT: begin
          if (report_ready) state_d = ST_HOLD;
        end
        ST_HOLD: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Payload registers change only on the transition into REPORT.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      ts_q    <= '0;
      chan_q  <= '0;
      idle_q  <= '0;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      ts_q    <= ts_q + CNT_W'(1);
      if (capture) begin
        chan_q <= axis_block_sigs;
        idle_q <= inst_idle_sigs;
        time_q <= ts_q;
      end
    end
  end

  assign report_valid = (state_q == ST_REPORT);
  assign deadlock     = (state_q == ST_HOLD);
  assign report_chan  = chan_q;
  assign report_idle  = idle_q;
  assign report_time  = time_q;

endmodule

// File: tb/tb_sobel_hls_deadlock_reporter.sv
// Directed bench for the deadlock reporter: default, THRESHOLD=1 and CNT_W=4 builds.
module tb_sobel_hls_deadlock_reporter;

  logic        clock = 1'b0;
  logic        reset;
  logic        block;
  logic [2:0]  axis_block_sigs;
  logic [2:0]  inst_idle_sigs;
  logic        clear;
  logic        report_ready;

  logic        v_a, v_b, v_c;
  logic        d_a, d_b, d_c;
  logic [2:0]  ch_a, ch_b, ch_c;
  logic [2:0]  id_a, id_b, id_c;
  logic [31:0] t_a, t_b;
  logic [3:0]  t_c;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int t16;

  always #5 clock = ~clock;

  sobel_hls_deadlock_reporter u_dut (
    .clock(clock), .reset(reset), .block(block),
    .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .clear(clear), .report_valid(v_a), .report_ready(report_ready),
    .report_chan(ch_a), .report_idle(id_a), .report_time(t_a), .deadlock(d_a)
  );

  sobel_hls_deadlock_reporter #(.THRESHOLD(1)) u_thr1 (
    .clock(clock), .reset(reset), .block(block),
    .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .clear(clear), .report_valid(v_b), .report_ready(report_ready),
    .report_chan(ch_b), .report_idle(id_b), .report_time(t_b), .deadlock(d_b)
  );

  sobel_hls_deadlock_reporter #(.CNT_W(4)) u_cw4 (
    .clock(clock), .reset(reset), .block(block),
    .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .clear(clear), .report_valid(v_c), .report_ready(report_ready),
    .report_chan(ch_c), .report_idle(id_c), .report_time(t_c), .deadlock(d_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: inputs already set for the current cycle; sample #1 after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; block = 1'b0; clear = 1'b0; report_ready = 1'b0;
    axis_block_sigs = 3'b000; inst_idle_sigs = 3'b000;
    tick(); tick();
    chk("rst_valid", 32'(v_a), 32'd0);
    chk("rst_dead",  32'(d_a), 32'd0);
    chk("rst_chan",  32'(ch_a), 32'd0);
    chk("rst_time",  t_a, 32'd0);
    reset = 1'b0;
    cyc = 0;

    // block high cycles 10..25, snapshot at 25
    for (int k = 0; k <= 25; k++) begin
      block           = (k >= 10);
      axis_block_sigs = (k == 25) ? 3'b010 : 3'b101;
      inst_idle_sigs  = (k == 25) ? 3'b011 : 3'b100;
      tick();
      if (k == 24) chk("pre_thr_valid", 32'(v_a), 32'd0);
    end
    chk("rep1_valid", 32'(v_a), 32'd1);
    chk("rep1_chan",  32'(ch_a), 32'd2);
    chk("rep1_idle",  32'(id_a), 32'd3);
    chk("rep1_time",  t_a, 32'd25);
    chk("rep1_dead",  32'(d_a), 32'd0);

    // stall 5 cycles with block dropped and changing inputs
    block = 1'b0; axis_block_sigs = 3'b111; inst_idle_sigs = 3'b000;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", 32'(v_a), 32'd1);
      chk("stall_chan",  32'(ch_a), 32'd2);
      chk("stall_time",  t_a, 32'd25);
    end
    report_ready = 1'b1;
    tick();
    report_ready = 1'b0;
    chk("hs_valid", 32'(v_a), 32'd0);
    chk("hs_dead",  32'(d_a), 32'd1);
    chk("hs_chan",  32'(ch_a), 32'd2);

    // HOLD ignores block and ready
    block = 1'b1; report_ready = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    report_ready = 1'b0;
    chk("hold_valid", 32'(v_a), 32'd0);
    chk("hold_dead",  32'(d_a), 32'd1);
    chk("hold_time",  t_a, 32'd25);

    // clear re-arms; payload retained
    block = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_dead",  32'(d_a), 32'd0);
    chk("clr_valid", 32'(v_a), 32'd0);
    chk("clr_chan",  32'(ch_a), 32'd2);

    t16 = 0;
    for (int k = 0; k < 16; k++) begin
      block = 1'b1;
      axis_block_sigs = (k == 15) ? 3'b001 : 3'b110;
      if (k == 15) t16 = cyc;
      tick();
      if (k == 14) chk("rep2_pre_valid", 32'(v_a), 32'd0);
    end
    chk("rep2_valid", 32'(v_a), 32'd1);
    chk("rep2_chan",  32'(ch_a), 32'd1);
    chk("rep2_time",  t_a, 32'(t16));

    // clear coinciding with handshake -> IDLE, not HOLD
    block = 1'b0; report_ready = 1'b1; clear = 1'b1;
    tick();
    report_ready = 1'b0; clear = 1'b0;
    chk("clrhs_valid", 32'(v_a), 32'd0);
    chk("clrhs_dead",  32'(d_a), 32'd0);

    // 15 high then low: no report, run count restarts
    block = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    chk("run15_valid", 32'(v_a), 32'd0);
    block = 1'b0;
    tick();
    chk("run15_low_valid", 32'(v_a), 32'd0);
    chk("run15_dead",      32'(d_a), 32'd0);
    block = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 14) chk("rerun_pre_valid", 32'(v_a), 32'd0);
    end
    chk("rerun_valid", 32'(v_a), 32'd1);

    // reset mid-handshake, with clear and block also asserted
    reset = 1'b1; report_ready = 1'b1;
    tick();
    chk("rstrep_valid", 32'(v_a), 32'd0);
    chk("rstrep_chan",  32'(ch_a), 32'd0);
    chk("rstrep_idle",  32'(id_a), 32'd0);
    chk("rstrep_time",  t_a, 32'd0);
    clear = 1'b1;
    tick();
    chk("rstclr_valid", 32'(v_a), 32'd0);
    chk("rstclr_dead",  32'(d_a), 32'd0);
    reset = 1'b0; clear = 1'b0; report_ready = 1'b0; block = 1'b0;
    cyc = 0;

    // THRESHOLD=1: single high sample at cycle 3
    for (int k = 0; k <= 3; k++) begin
      block = (k == 3);
      axis_block_sigs = (k == 3) ? 3'b100 : 3'b000;
      tick();
      if (k == 2) chk("thr1_pre_valid", 32'(v_b), 32'd0);
    end
    chk("thr1_valid", 32'(v_b), 32'd1);
    chk("thr1_chan",  32'(ch_b), 32'd4);
    chk("thr1_time",  t_b, 32'd3);
    chk("thr1_dflt_valid", 32'(v_a), 32'd0);

    // CNT_W=4: block high cycles 5..20 -> report at cycle 20, time wraps to 4
    for (int k = 4; k <= 20; k++) begin
      block = (k >= 5);
      tick();
      if (k == 19) chk("cw4_pre_valid", 32'(v_c), 32'd0);
    end
    chk("cw4_valid", 32'(v_c), 32'd1);
    chk("cw4_time",  32'(t_c), 32'd4);
    chk("cw4_wide_time", t_a, 32'd20);
    chk("thr1_stable_time", t_b, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
